rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (requester A) and a long-latency unit such as mul/div (requester B).
- Buffers one B result and keeps a busy scoreboard of registers with B results still outstanding.
- Raises a hazard to decode and a starvation stall so B results always retire.
- Sits between the WB stage / long-latency unit and the register file's RegWrite/RDaddr/RDdata inputs.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width (2**ADDR_W registers)
STARVE_LIMIT, 4, cycles a buffered B entry may wait before bubble request

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
a_valid_i  input  1  pipeline WB write request; always accepted, no ready
a_addr_i  input  ADDR_W  WB destination register
a_data_i  input  DATA_W  WB data
b_valid_i  input  1  long-latency result valid
b_ready_o  output  1  B result accepted when b_valid_i & b_ready_o
b_addr_i  input  ADDR_W  B destination register
b_data_i  input  DATA_W  B data
issue_valid_i  input  1  B-type instruction issued this cycle; marks issue_addr_i busy
issue_addr_i  input  ADDR_W  destination of issued B instruction
rs_addr_i  input  ADDR_W  decode-stage source 1
rt_addr_i  input  ADDR_W  decode-stage source 2
rd_addr_i  input  ADDR_W  decode-stage destination
hazard_o  output  1  rs, rt or rd busy (combinational)
bubble_req_o  output  1  request pipeline to send an empty WB slot
RegWrite_o  output  1  register file write enable
RDaddr_o  output  ADDR_W  register file write address
RDdata_o  output  DATA_W  register file write data

Behaviour:
- Reset (rst_i low, async): buf_valid=0, busy=0, starve counter=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0, bubble_req_o=0. b_ready_o=0 while rst_i is low.
- Write-port outputs are registered: a request selected in cycle N appears on RegWrite_o/RDaddr_o/RDdata_o in cycle N+1. RegWrite_o is high for exactly one cycle per write.
- Selection each cycle:
  - a_valid_i=1 and a_addr_i!=0: A wins.
  - Else if buf_valid=1: the buffer drains, buf_valid clears next cycle.
  - Else: RegWrite_o=0 next cycle.
  - A with a_addr_i=0 is dropped and leaves the slot free for the buffer.
- b_ready_o = rst_i & !buf_valid. An accepted B result loads the buffer; it never bypasses straight to the port. Minimum B-to-port latency is 2 cycles.
- B result with addr 0: accepted, then discarded at drain with no write. Its busy bit is never set.
- Draining and accepting in the same cycle is not allowed. b_ready_o is already 0 whenever buf_valid=1, so peak B throughput is 1 result per 2 cycles.
- Scoreboard, busy[2**ADDR_W-1:0]:
  - Set: issue_valid_i with issue_addr_i!=0 sets its bit next cycle.
  - Clear: the bit clears in the cycle the buffered entry drains.
  - Set and clear of the same address in the same cycle: set wins.
  - busy[0] is always 0.
- hazard_o = busy[rs] | busy[rt] | busy[rd]. Decode stalls on it, which rules out RAW and WAW against pending B results.
- Starvation: the counter increments each cycle buf_valid=1 and the buffer loses to A; it clears on drain.
  - bubble_req_o=1 while counter >= STARVE_LIMIT, until drain.
  - With a bubble, A is idle and the buffer drains.
- Reset mid-operation: the buffered entry and busy bits are lost; any write in flight is suppressed.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, REG_ZERO constant, write-request struct {valid, addr, data}.
- One natural sub-module: rf_scoreboard (busy vector, set/clear priority, three-port busy lookup).
- Arbitration, buffer and starvation counter stay in the top module.

Test Plan:
- Reset released, A writes r5=0x1234 at cycle N -> RegWrite_o=1, RDaddr_o=5, RDdata_o=0x1234 at N+1 only; b_ready_o=1.
- B r8=0xDEAD with no A traffic -> accepted, b_ready_o=0 next cycle, port writes r8=0xDEAD 2 cycles after acceptance, b_ready_o returns to 1.
- issue r8, then decode rs=8 -> hazard_o=1 until the cycle r8 drains; simultaneous re-issue of r8 at drain leaves busy[8]=1.
- B buffered, A valid nonzero every cycle -> bubble_req_o=1 after 4 lost cycles; one A idle cycle drains B, bubble_req_o=0 next cycle.
- A a_addr_i=0 with buffer holding r3 -> r3 written that slot; r0 never written. B addr 0 -> no RegWrite_o pulse.
- rst_i low while buffer full and busy[3]=1 -> all outputs 0 immediately, busy cleared, no write after release.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_pkg
// Shared definitions for the register-file write-port arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default data and register-address widths
//   DEF_STARVE_LIMIT        : default wait (in lost cycles) before a bubble
//                             is requested for a buffered long-latency result
//   REG_ZERO                : architectural zero register, never written
//   wr_req_t                : one register-file write {valid, addr, data}
// -----------------------------------------------------------------------------
package rf_write_arbiter_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_STARVE_LIMIT = 4;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wr_req_t;

endpackage : rf_write_arbiter_pkg

// File: rtl/rf_write_arbiter_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Busy bits for destination registers that still have a long-latency result
// outstanding, plus a three-port lookup for the decode stage.
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   set_valid_i/addr_i  : B-type instruction issued; mark destination busy
//   clr_valid_i/addr_i  : buffered B result drains; release its destination
//   rs/rt/rd_addr_i     : decode-stage register numbers to look up
//   hazard_o            : any of rs/rt/rd busy (combinational)
// -----------------------------------------------------------------------------
module rf_scoreboard
    import rf_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_valid_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_valid_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              hazard_o
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear is applied first so a re-issue to the same register in the drain
    // cycle leaves the bit set: the new instruction is still outstanding.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_valid_i && (set_addr_i != ADDR_W'(REG_ZERO))) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard_o = busy_q[rs_addr_i] | busy_q[rt_addr_i] | busy_q[rd_addr_i];

endmodule : rf_scoreboard

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port between the in-order pipeline
// writeback (A, always accepted) and a long-latency unit (B, valid/ready).
// B results go through a one-entry buffer; A has priority for the port, and a
// starvation counter asks the pipeline for an empty WB slot so B always retires.
//   clk_i, rst_i                  : clock, asynchronous active-low reset
//   a_valid_i/a_addr_i/a_data_i   : WB write request (addr 0 is dropped)
//   b_valid_i/b_addr_i/b_data_i   : B result; b_ready_o accepts it
//   issue_valid_i/issue_addr_i    : B-type issue, marks destination busy
//   rs/rt/rd_addr_i, hazard_o     : decode-stage busy lookup
//   bubble_req_o                  : request an idle WB slot for the buffer
//   RegWrite_o/RDaddr_o/RDdata_o  : registered write port to the register file
// Handshake: a B result transfers on a cycle where b_valid_i and b_ready_o are
// both high; b_valid_i may not depend on b_ready_o, and b_ready_o only rises
// when the buffer is empty, so a transfer never coincides with a drain.
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_valid_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              hazard_o,
    output logic              bubble_req_o,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o
);

    localparam int STARVE_W = ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // One-entry B buffer
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q,  buf_addr_d;
    logic [DATA_W-1:0] buf_data_q,  buf_data_d;

    // Lost-arbitration counter for the buffered entry
    logic [STARVE_W-1:0] starve_q, starve_d;

    // Registered write port
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,  wr_data_d;

    logic a_win;
    logic drain;
    logic accept;

    assign a_win     = a_valid_i && (a_addr_i != ADDR_W'(REG_ZERO));
    assign drain     = buf_valid_q && !a_win;
    assign b_ready_o = rst_i & ~buf_valid_q;
    assign accept    = b_valid_i & b_ready_o;

    always_comb begin
        wr_valid_d  = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        starve_d    = starve_q;

        if (a_win) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = a_addr_i;
            wr_data_d  = a_data_i;
        end else if (drain && (buf_addr_q != ADDR_W'(REG_ZERO))) begin
            // A zero-destination B result is consumed here without a write.
            wr_valid_d = 1'b1;
            wr_addr_d  = buf_addr_q;
            wr_data_d  = buf_data_q;
        end

        if (drain) begin
            buf_valid_d = 1'b0;
            starve_d    = '0;
        end else if (buf_valid_q && a_win && (starve_q < STARVE_MAX)) begin
            // Saturates at the limit; the bubble request holds until drain.
            starve_d = starve_q + 1'b1;
        end

        if (accept) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = b_addr_i;
            buf_data_d  = b_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            starve_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            starve_q    <= starve_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bubble_req_o = (starve_q >= STARVE_MAX);
    assign RegWrite_o   = wr_valid_q;
    assign RDaddr_o     = wr_addr_q;
    assign RDdata_o     = wr_data_q;

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_valid_i (issue_valid_i),
        .set_addr_i  (issue_addr_i),
        .clr_valid_i (drain),
        .clr_addr_i  (buf_addr_q),
        .rs_addr_i   (rs_addr_i),
        .rt_addr_i   (rt_addr_i),
        .rd_addr_i   (rd_addr_i),
        .hazard_o    (hazard_o)
    );

endmodule : rf_write_arbiter
